// File: rtl/n64_vdemux_vinfo_if.sv
// N64 video bus bundle: multiplexed VD input side plus demuxed pixel word and mode outputs.
// master = bus source / consumer side, slave = the demux stage.
interface n64_vdemux_vinfo_if #(
  parameter int unsigned color_width_i = 7
);
  localparam int unsigned VdataW = 4 + 3 * color_width_i;

  logic                     nVDSYNC;
  logic [color_width_i-1:0] VD_i;
  logic [VdataW-1:0]        vdata_o;
  logic                     vdata_valid_o;
  logic [1:0]               vinfo_o;
  logic                     field_o;
  logic                     phase_err_o;

  modport master (
    output nVDSYNC,
    output VD_i,
    input  vdata_o,
    input  vdata_valid_o,
    input  vinfo_o,
    input  field_o,
    input  phase_err_o
  );

  modport slave (
    input  nVDSYNC,
    input  VD_i,
    output vdata_o,
    output vdata_valid_o,
    output vinfo_o,
    output field_o,
    output phase_err_o
  );
endinterface

// File: rtl/n64_vdemux_vinfo.sv
// N64 VD bus demultiplexer and video-mode detector (PAL/NTSC, 240p/480i, field), VCLK domain.
// Optional feature macro: VDEMUX_PHASE_CHECK_EN (phase-error pulse and history reset).
module n64_vdemux_vinfo #(
  parameter int unsigned color_width_i = 7,
  parameter logic [9:0]  PAL_THRESH    = 10'd288
) (
  input logic               VCLK,
  input logic               nVRST,
  n64_vdemux_vinfo_if.slave vid
);
  localparam int unsigned CW     = color_width_i;
  localparam int unsigned VdataW = 4 + 3 * CW;

  logic [1:0]        phase_q, phase_d;
  logic              word_ok_q, word_ok_d;
  logic [3:0]        sync_q;
  logic [CW-1:0]     r_q, g_q, b_q;
  logic              done_q;
  logic [VdataW-1:0] vdata_q;
  logic              valid_q;
  logic [9:0]        cnt_q, cnt_d;
  logic [9:0]        cur_q, cur_d;
  logic [9:0]        prev_q, prev_d;
  logic [1:0]        hist_q, hist_d;
  logic [1:0]        vinfo_q, vinfo_d;
  logic              field_q, field_d;
  logic              sync_cap, hs_fall, vs_fall;

  // word_ok: a real sync word has been seen since reset, so phase counts are meaningful
  always_comb begin
    phase_d   = vid.nVDSYNC ? phase_q + 2'd1 : 2'd0;
    word_ok_d = word_ok_q | ~vid.nVDSYNC;
    sync_cap  = (phase_d == 2'd0) & word_ok_d;
    hs_fall   = sync_cap & sync_q[1] & ~vid.VD_i[1];
    vs_fall   = sync_cap & sync_q[3] & ~vid.VD_i[3];
  end

`ifdef VDEMUX_PHASE_CHECK_EN
  logic phase_err;
  logic phase_err_q;
  assign phase_err = ~vid.nVDSYNC & word_ok_q & (phase_q != 2'd3);
`endif

  always_comb begin
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    prev_d  = prev_q;
    hist_d  = hist_q;
    vinfo_d = vinfo_q;
    field_d = field_q;
    // A vsync fall wins over a coincident hsync fall
    if (vs_fall) begin
      cnt_d  = '0;
      cur_d  = cnt_q;
      prev_d = cur_q;
      if (hist_q != 2'd2) hist_d = hist_q + 2'd1;
    end else if (hs_fall && (cnt_q != 10'h3FF)) begin
      cnt_d = cnt_q + 10'd1;
    end
`ifdef VDEMUX_PHASE_CHECK_EN
    if (phase_err) hist_d = 2'd0;
`endif
    if (vs_fall && (hist_d == 2'd2)) begin
      vinfo_d = {cnt_q > PAL_THRESH, cnt_q != cur_q};
      field_d = (cnt_q != cur_q) & cnt_q[0];
    end
  end

  always_ff @(posedge VCLK or negedge nVRST) begin
    if (!nVRST) begin
      phase_q     <= 2'd0;
      word_ok_q   <= 1'b0;
      sync_q      <= 4'hF;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      done_q      <= 1'b0;
      vdata_q     <= {4'hF, {(3 * CW){1'b0}}};
      valid_q     <= 1'b0;
      cnt_q       <= '0;
      cur_q       <= '0;
      prev_q      <= '0;
      hist_q      <= 2'd0;
      vinfo_q     <= 2'b00;
      field_q     <= 1'b0;
`ifdef VDEMUX_PHASE_CHECK_EN
      phase_err_q <= 1'b0;
`endif
    end else begin
      phase_q   <= phase_d;
      word_ok_q <= word_ok_d;
      if (sync_cap) sync_q <= vid.VD_i[3:0];
      if (phase_d == 2'd1) r_q <= vid.VD_i;
      if (phase_d == 2'd2) g_q <= vid.VD_i;
      if (phase_d == 2'd3) b_q <= vid.VD_i;
      done_q  <= (phase_d == 2'd3) & word_ok_q;
      valid_q <= done_q;
      // sync_q still holds this word's nibble: the next one lands on the same edge
      if (done_q) vdata_q <= {sync_q, r_q, g_q, b_q};
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      prev_q  <= prev_d;
      hist_q  <= hist_d;
      vinfo_q <= vinfo_d;
      field_q <= field_d;
`ifdef VDEMUX_PHASE_CHECK_EN
      phase_err_q <= phase_err;
`endif
    end
  end

  assign vid.vdata_o       = vdata_q;
  assign vid.vdata_valid_o = valid_q;
  assign vid.vinfo_o       = vinfo_q;
  assign vid.field_o       = field_q;
`ifdef VDEMUX_PHASE_CHECK_EN
  assign vid.phase_err_o   = phase_err_q;
`else
  assign vid.phase_err_o   = 1'b0;
`endif

endmodule
